// File: rtl/sumador_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : sumador_pkg                                              |
// | Purpose : Shared definitions for the digit-serial adder: FSM state |
// |           encoding and the digit-counter width helper.             |
// | Ports   : none (package)                                           |
// | Rev     : 1.0  initial release                                     |
// +--------------------------------------------------------------------+
package sumador_pkg;

  typedef enum logic [1:0] {
    REPOSO  = 2'd0,
    SUMANDO = 2'd1,
    FIN     = 2'd2
  } estado_t;

  // Counter must hold 0..N-1 with N = ancho/digito; never narrower than 1 bit.
  function automatic int ancho_contador(input int ancho, input int digito);
    int n;
    n = ancho / digito;
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sumador_digito.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : sumador_digito                                           |
// | Purpose : Combinational DIGITO-bit ripple adder built from         |
// |           cascaded full-adder cells.                               |
// | Ports   : A, B            - DIGITO-bit addends                     |
// |           AcarreoEntrada  - carry into bit 0                       |
// |           Suma            - DIGITO-bit sum                         |
// |           AcarreoSalida   - carry out of bit DIGITO-1              |
// | Rev     : 1.0  initial release                                     |
// +--------------------------------------------------------------------+
module sumador_digito #(
  parameter int DIGITO = 1
) (
  input  logic [DIGITO-1:0] A,
  input  logic [DIGITO-1:0] B,
  input  logic              AcarreoEntrada,
  output logic [DIGITO-1:0] Suma,
  output logic              AcarreoSalida
);

  logic [DIGITO:0] w_c;

  assign w_c[0] = AcarreoEntrada;

  for (genvar i = 0; i < DIGITO; i++) begin : g_celda
    assign Suma[i]    = A[i] ^ B[i] ^ w_c[i];
    assign w_c[i + 1] = (A[i] & B[i]) | (w_c[i] & (A[i] ^ B[i]));
  end

  assign AcarreoSalida = w_c[DIGITO];

endmodule
`default_nettype wire

// File: rtl/sumador_serie.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : sumador_serie                                            |
// | Purpose : Digit-serial adder. Adds X + Y + AcarreoEntrada, DIGITO  |
// |           bits per clock, with a registered carry between digits.  |
// |           Start/busy/done handshake; result held until the next    |
// |           completed operation.                                     |
// | Ports   : Reloj, Reset (async, active-high)                        |
// |           Inicio, X, Y, AcarreoEntrada  - request and operands     |
// |           Resta (only with SUMADOR_SERIE_RESTA_EN) - subtract X-Y  |
// |           Ocupado, Listo                - status                   |
// |           Salida, AcarreoSalida         - registered result        |
// | Options : `define SUMADOR_SERIE_RESTA_EN adds the Resta input.     |
// | Rev     : 1.0  initial release                                     |
// +--------------------------------------------------------------------+
module sumador_serie
  import sumador_pkg::*;
#(
  parameter int ANCHO  = 8,
  parameter int DIGITO = 1
) (
  input  logic             Reloj,
  input  logic             Reset,
  input  logic             Inicio,
  input  logic [ANCHO-1:0] X,
  input  logic [ANCHO-1:0] Y,
  input  logic             AcarreoEntrada,
`ifdef SUMADOR_SERIE_RESTA_EN
  input  logic             Resta,
`endif
  output logic             Ocupado,
  output logic             Listo,
  output logic [ANCHO-1:0] Salida,
  output logic             AcarreoSalida
);

  localparam int              C_N      = ANCHO / DIGITO;
  localparam int              C_CW     = ancho_contador(ANCHO, DIGITO);
  localparam logic [C_CW-1:0] C_ULTIMO = C_CW'(C_N - 1);

  if ((DIGITO < 1) || (DIGITO > ANCHO) || ((ANCHO % DIGITO) != 0)) begin : g_param_invalido
    $error("sumador_serie: ANCHO must be a multiple of DIGITO and 1 <= DIGITO <= ANCHO");
  end

  estado_t           r_estado;
  estado_t           w_estado_sig;
  logic              w_aceptar;
  logic [ANCHO-1:0]  r_a;
  logic [ANCHO-1:0]  r_b;
  logic              r_acarreo;
  logic [C_CW-1:0]   r_cuenta;
  logic [ANCHO-1:0]  r_suma;
  logic [ANCHO-1:0]  r_salida;
  logic              r_acarreo_salida;
  logic [ANCHO-1:0]  w_b_carga;
  logic              w_c_carga;
  logic [DIGITO-1:0] w_digito;
  logic              w_acarreo;
  logic [ANCHO-1:0]  w_suma_sig;

  // Subtraction is X + ~Y + 1: invert Y on capture and force the initial carry.
  always_comb begin
    w_b_carga = Y;
    w_c_carga = AcarreoEntrada;
`ifdef SUMADOR_SERIE_RESTA_EN
    if (Resta) begin
      w_b_carga = ~Y;
      w_c_carga = 1'b1;
    end
`endif
  end

  sumador_digito #(
    .DIGITO (DIGITO)
  ) u_digito (
    .A              (r_a[DIGITO-1:0]),
    .B              (r_b[DIGITO-1:0]),
    .AcarreoEntrada (r_acarreo),
    .Suma           (w_digito),
    .AcarreoSalida  (w_acarreo)
  );

  // New digit enters at the top; after N digits the first one sits at bit 0.
  if (DIGITO == ANCHO) begin : g_sin_desplazar
    assign w_suma_sig = w_digito;
  end else begin : g_desplazar
    assign w_suma_sig = {w_digito, r_suma[ANCHO-1:DIGITO]};
  end

  always_comb begin
    w_estado_sig = r_estado;
    w_aceptar    = 1'b0;
    Ocupado      = 1'b0;
    Listo        = 1'b0;
    case (r_estado)
      REPOSO: begin
        if (Inicio) begin
          w_aceptar    = 1'b1;
          w_estado_sig = SUMANDO;
        end
      end
      SUMANDO: begin
        Ocupado = 1'b1;
        if (r_cuenta == C_ULTIMO) begin
          w_estado_sig = FIN;
        end
      end
      FIN: begin
        Listo = 1'b1;
        if (Inicio) begin
          w_aceptar    = 1'b1;
          w_estado_sig = SUMANDO;
        end else begin
          w_estado_sig = REPOSO;
        end
      end
      default: begin
        w_estado_sig = REPOSO;
      end
    endcase
  end

  always_ff @(posedge Reloj or posedge Reset) begin
    if (Reset) begin
      r_estado         <= REPOSO;
      r_a              <= '0;
      r_b              <= '0;
      r_acarreo        <= 1'b0;
      r_cuenta         <= '0;
      r_suma           <= '0;
      r_salida         <= '0;
      r_acarreo_salida <= 1'b0;
    end else begin
      r_estado <= w_estado_sig;
      if (w_aceptar) begin
        r_a       <= X;
        r_b       <= w_b_carga;
        r_acarreo <= w_c_carga;
        r_cuenta  <= '0;
      end else if (r_estado == SUMANDO) begin
        r_a       <= r_a >> DIGITO;
        r_b       <= r_b >> DIGITO;
        r_acarreo <= w_acarreo;
        r_cuenta  <= r_cuenta + C_CW'(1);
        r_suma    <= w_suma_sig;
        // Publish on the edge that enters FIN so the result is valid with Listo.
        if (r_cuenta == C_ULTIMO) begin
          r_salida         <= w_suma_sig;
          r_acarreo_salida <= w_acarreo;
        end
      end
    end
  end

  assign Salida        = r_salida;
  assign AcarreoSalida = r_acarreo_salida;

endmodule
`default_nettype wire
